// File: rtl/vec_row_packer.sv
// Packs 32-bit host beats LSB-first into V_WIDTH-bit rows and commits each row to the X-vector BRAM.
// Optional build macro VPACK_PAD_EN: s_wlast ends a row early and the remaining words are zero.
module vec_row_packer #(
   parameter int V_WIDTH = 1408
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_start,
   input  logic [7:0]         cfg_row_addr,
   input  logic [8:0]         cfg_num_rows,
   input  logic               s_wvalid,
   output logic               s_wready,
   input  logic [31:0]        s_wdata,
   input  logic               s_wlast,
   output logic [7:0]         convdp_x_addr,
   output logic [V_WIDTH-1:0] convdp_x_data,
   output logic [7:0]         convdp_x_we,
   output logic               busy,
   output logic               done
);

   localparam int WORDS = V_WIDTH / 32;
   localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t             state_q;
   logic [WCW-1:0]     word_q;
   logic [8:0]         rows_left_q;
   logic [7:0]         row_addr_q;
   logic [V_WIDTH-1:0] pack_q;
   logic [V_WIDTH-1:0] pack_d;
   logic [7:0]         addr_q;
   logic [V_WIDTH-1:0] data_q;
   logic [7:0]         we_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic               last_beat;

   // Pack register with the incoming beat dropped into the current word slot.
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign pack_d[32*gi +: 32] = (word_q == WCW'(gi)) ? s_wdata : pack_q[32*gi +: 32];
      end
   endgenerate

`ifdef VPACK_PAD_EN
   assign last_beat = (word_q == WCW'(WORDS - 1)) || s_wlast;
`else
   logic unused_wlast;
   assign unused_wlast = s_wlast;
   assign last_beat    = (word_q == WCW'(WORDS - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         rows_left_q <= '0;
         row_addr_q  <= '0;
         pack_q      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         we_q        <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         we_q   <= '0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  if (cfg_num_rows == 9'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q     <= FILL;
                     row_addr_q  <= cfg_row_addr;
                     rows_left_q <= cfg_num_rows;
                     word_q      <= '0;
                     pack_q      <= '0;
                     ready_q     <= 1'b1;
                     busy_q      <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (s_wvalid && ready_q) begin
                  if (last_beat) begin
                     // Row image and address are captured here so the BRAM sees them in COMMIT.
                     data_q  <= pack_d;
                     addr_q  <= row_addr_q;
                     we_q    <= 8'hFF;
                     done_q  <= (rows_left_q == 9'd1);
                     pack_q  <= '0;
                     word_q  <= '0;
                     ready_q <= 1'b0;
                     state_q <= COMMIT;
                  end else begin
                     pack_q <= pack_d;
                     word_q <= word_q + WCW'(1);
                  end
               end
            end
            COMMIT: begin
               row_addr_q  <= row_addr_q + 8'd1;
               rows_left_q <= rows_left_q - 9'd1;
               if (rows_left_q == 9'd1) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= FILL;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_wready      = ready_q;
   assign convdp_x_addr = addr_q;
   assign convdp_x_data = data_q;
   assign convdp_x_we   = we_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_vec_row_packer.sv
// Directed-sequence bench for vec_row_packer with randomized beat data/gaps and a row-image reference model.
module tb_vec_row_packer;

   localparam int V = 1408;
   localparam int W = V / 32;

   logic          clk;
   logic          rst_n;
   logic          cfg_start;
   logic [7:0]    cfg_row_addr;
   logic [8:0]    cfg_num_rows;
   logic          s_wvalid;
   logic          s_wready;
   logic [31:0]   s_wdata;
   logic          s_wlast;
   logic [7:0]    convdp_x_addr;
   logic [V-1:0]  convdp_x_data;
   logic [7:0]    convdp_x_we;
   logic          busy;
   logic          done;

   vec_row_packer #(.V_WIDTH(V)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_row_addr(cfg_row_addr),
      .cfg_num_rows(cfg_num_rows), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_wdata(s_wdata), .s_wlast(s_wlast), .convdp_x_addr(convdp_x_addr),
      .convdp_x_data(convdp_x_data), .convdp_x_we(convdp_x_we), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] beats [0:2*W-1];

   // Observed BRAM traffic and handshake statistics.
   logic [7:0]   wr_addr [$];
   logic [V-1:0] wr_data [$];
   int done_cnt       = 0;
   int done_we_cnt    = 0;
   int ready_bad      = 0;
   int we_bad         = 0;
   int busy_after_bad = 0;
   int hs_cnt         = 0;
   logic prev_done    = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (convdp_x_we != 8'h00) begin
            wr_addr.push_back(convdp_x_addr);
            wr_data.push_back(convdp_x_data);
            if (convdp_x_we !== 8'hFF) we_bad++;
            if (s_wready) ready_bad++;
         end
         if (done) begin
            done_cnt++;
            if (convdp_x_we == 8'hFF) done_we_cnt++;
         end
         if (prev_done && busy) busy_after_bad++;
         prev_done = done;
      end
   end

   always @(posedge clk) if (rst_n && s_wvalid && s_wready) hs_cnt++;

   // Expected row: first n_valid beats from base placed LSB-first, remaining words zero.
   function automatic logic [V-1:0] row_of(int base, int n_valid);
      logic [V-1:0] r;
      r = '0;
      for (int k = 0; k < W; k++)
         if (k < n_valid) r[32*k +: 32] = beats[base + k];
      return r;
   endfunction

   function automatic logic [7:0] get_addr(int i);
      if (i < wr_addr.size()) return wr_addr[i];
      return 8'hxx;
   endfunction

   function automatic logic [V-1:0] get_data(int i);
      if (i < wr_data.size()) return wr_data[i];
      return {V{1'bx}};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_row(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
      int bad;
      bad = -1;
      for (int k = W - 1; k >= 0; k--)
         if (obs[32*k +: 32] !== exp[32*k +: 32]) bad = k;
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         if (bad >= 0)
            $error("FAIL %s: word %0d got %h want %h", tag, bad, obs[32*bad +: 32], exp[32*bad +: 32]);
         else
            $error("FAIL %s: row differs", tag);
      end
   endtask

   task automatic start(input logic [7:0] addr, input logic [8:0] n);
      @(negedge clk);
      cfg_start    = 1'b1;
      cfg_row_addr = addr;
      cfg_num_rows = n;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic send_beats(input int base, input int n, input bit gaps, input int last_idx);
      int idx;
      int guard;
      bit v;
      bit rdy;
      idx   = base;
      guard = 0;
      while (idx < base + n && guard < 4000) begin
         @(negedge clk);
         v        = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_wvalid = v;
         s_wdata  = v ? beats[idx] : $urandom;
         s_wlast  = v && (idx == last_idx);
         rdy      = s_wready;
         @(posedge clk);
         if (v && rdy) idx++;
         guard++;
      end
      @(negedge clk);
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
      check("send_complete", idx, base + n);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      check("idle_reached", busy, 0);
   endtask

   int s_wr, s_done, s_dwe, s_hs;

   task automatic snap();
      s_wr   = wr_addr.size();
      s_done = done_cnt;
      s_dwe  = done_we_cnt;
      s_hs   = hs_cnt;
   endtask

   initial begin
      rst_n = 1'b0; cfg_start = 1'b0; cfg_row_addr = '0; cfg_num_rows = '0;
      s_wvalid = 1'b0; s_wdata = '0; s_wlast = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wready", s_wready, 0);
      check("rst_we", convdp_x_we, 0);
      check("rst_addr", convdp_x_addr, 0);
      check("rst_data", (convdp_x_data == '0), 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // One row of ascending beats, no gaps.
      for (int k = 0; k < W; k++) beats[k] = k;
      snap();
      start(8'h10, 9'd1);
      send_beats(0, W, 1'b0, -1);
      wait_idle();
      check("t1_writes", wr_addr.size() - s_wr, 1);
      check("t1_addr", get_addr(s_wr), 8'h10);
      check_row("t1_data", get_data(s_wr), row_of(0, W));
      check("t1_done", done_cnt - s_done, 1);
      check("t1_done_with_we", done_we_cnt - s_dwe, 1);

      // Two rows from 8'hFF with random gaps: address wraps to 8'h00.
      for (int k = 0; k < 2*W; k++) beats[k] = $urandom;
      snap();
      start(8'hFF, 9'd2);
      send_beats(0, 2*W, 1'b1, -1);
      wait_idle();
      check("t2_writes", wr_addr.size() - s_wr, 2);
      check("t2_addr0", get_addr(s_wr), 8'hFF);
      check("t2_addr1", get_addr(s_wr + 1), 8'h00);
      check_row("t2_data0", get_data(s_wr), row_of(0, W));
      check_row("t2_data1", get_data(s_wr + 1), row_of(W, W));
      check("t2_beats", hs_cnt - s_hs, 2*W);
      check("t2_done", done_cnt - s_done, 1);

      // Zero-row start: done pulses next cycle, no traffic.
      snap();
      @(negedge clk);
      cfg_start = 1'b1; cfg_row_addr = 8'h77; cfg_num_rows = 9'd0;
      @(negedge clk);
      cfg_start = 1'b0;
      check("t3_done_pulse", done, 1);
      check("t3_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("t3_busy_after", busy, 0);
      check("t3_writes", wr_addr.size() - s_wr, 0);
      check("t3_done_cnt", done_cnt - s_done, 1);

      // Start issued mid-transfer must be ignored.
      for (int k = 0; k < W; k++) beats[k] = $urandom;
      snap();
      start(8'h20, 9'd1);
      send_beats(0, W/2, 1'b1, -1);
      start(8'h55, 9'd3);
      send_beats(W/2, W - W/2, 1'b1, -1);
      wait_idle();
      repeat (8) @(negedge clk);
      check("t4_writes", wr_addr.size() - s_wr, 1);
      check("t4_addr", get_addr(s_wr), 8'h20);
      check_row("t4_data", get_data(s_wr), row_of(0, W));
      check("t4_done", done_cnt - s_done, 1);
      check("t4_busy", busy, 0);

      // s_wlast on beat 9.
      for (int k = 0; k < W; k++) beats[k] = (k < 10) ? (k + 1) : $urandom;
      snap();
      start(8'h33, 9'd1);
      send_beats(0, 10, 1'b0, 9);
      repeat (4) @(negedge clk);
`ifdef VPACK_PAD_EN
      check("t5_writes", wr_addr.size() - s_wr, 1);
      check("t5_addr", get_addr(s_wr), 8'h33);
      check_row("t5_data", get_data(s_wr), row_of(0, 10));
      check("t5_busy", busy, 0);
`else
      check("t5_no_early_write", wr_addr.size() - s_wr, 0);
      check("t5_still_busy", busy, 1);
      send_beats(10, W - 10, 1'b0, -1);
      wait_idle();
      check("t5_writes", wr_addr.size() - s_wr, 1);
      check("t5_addr", get_addr(s_wr), 8'h33);
      check_row("t5_data", get_data(s_wr), row_of(0, W));
`endif

      // Reset after 20 beats discards the partial row.
      for (int k = 0; k < W; k++) beats[k] = $urandom;
      snap();
      start(8'h40, 9'd1);
      send_beats(0, 20, 1'b0, -1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_wready", s_wready, 0);
      check("t6_rst_we", convdp_x_we, 0);
      check("t6_rst_addr", convdp_x_addr, 0);
      check("t6_rst_data", (convdp_x_data == '0), 1);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("t6_no_write", wr_addr.size() - s_wr, 0);
      for (int k = 0; k < W; k++) beats[k] = $urandom;
      snap();
      start(8'h41, 9'd1);
      send_beats(0, W, 1'b1, -1);
      wait_idle();
      check("t6_writes", wr_addr.size() - s_wr, 1);
      check("t6_addr", get_addr(s_wr), 8'h41);
      check_row("t6_data", get_data(s_wr), row_of(0, W));

      // Global invariants over the whole run.
      check("inv_ready_low_in_commit", ready_bad, 0);
      check("inv_we_all_slices", we_bad, 0);
      check("inv_busy_drops_after_done", busy_after_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
